// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants: immediate format codes, opcodes, field positions.
package legv8_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_B    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_I    = 3'd3,
    FMT_D    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_e;

  // B-format, [31:26]
  localparam logic [5:0] OP_B  = 6'b000101;
  localparam logic [5:0] OP_BL = 6'b100101;

  // CB-format, [31:24]
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  // I-format, [31:22]
  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;

  // D-format, [31:21]
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_STURW  = 11'b10111000000;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;
  localparam logic [10:0] OP_STURB  = 11'b00111000000;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_STURH  = 11'b01111000000;

  // IW-format, [31:23]
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;

  // Immediate field positions
  localparam int unsigned B_IMM_MSB  = 25;
  localparam int unsigned CB_IMM_MSB = 23;
  localparam int unsigned CB_IMM_LSB = 5;
  localparam int unsigned I_IMM_MSB  = 21;
  localparam int unsigned I_IMM_LSB  = 10;
  localparam int unsigned D_IMM_MSB  = 20;
  localparam int unsigned D_IMM_LSB  = 12;
  localparam int unsigned IW_IMM_MSB = 20;
  localparam int unsigned IW_IMM_LSB = 5;
  localparam int unsigned IW_HW_MSB  = 22;
  localparam int unsigned IW_HW_LSB  = 21;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / immediate-out stream bundle for the immediate generator stage.
interface imm_gen_stage_if #(
  parameter int unsigned DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_fmt;
  logic              out_illegal;
  logic [DATA_W-1:0] out_pc;

  // Upstream/downstream environment side
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
  );

  // Stage side
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate decode and extension (first match B, CB, I, D, IW).
module imm_decode
  import legv8_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter bit          IMM12_SIGNED = 1'b1,
  parameter bit          BR_SHIFT2    = 1'b0
) (
  input  logic [31:0]       instr_i,
  output logic [DATA_W-1:0] imm_o,
  output fmt_e              fmt_o,
  output logic              illegal_o
);

  logic [1:0]        hw;
  logic [63:0]       iw_wide;
  logic [DATA_W-1:0] br_ext;

  // Decode the format and build the extended immediate
  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b1;
    br_ext    = '0;
    hw        = instr_i[IW_HW_MSB:IW_HW_LSB];
    iw_wide   = 64'(instr_i[IW_IMM_MSB:IW_IMM_LSB]) << {hw, 4'b0000};

    if (instr_i[31:26] inside {OP_B, OP_BL}) begin
      fmt_o     = FMT_B;
      illegal_o = 1'b0;
      br_ext    = {{(DATA_W-26){instr_i[B_IMM_MSB]}}, instr_i[B_IMM_MSB:0]};
      imm_o     = BR_SHIFT2 ? (br_ext << 2) : br_ext;
    end else if (instr_i[31:24] inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
      fmt_o     = FMT_CB;
      illegal_o = 1'b0;
      br_ext    = {{(DATA_W-19){instr_i[CB_IMM_MSB]}}, instr_i[CB_IMM_MSB:CB_IMM_LSB]};
      imm_o     = BR_SHIFT2 ? (br_ext << 2) : br_ext;
    end else if (instr_i[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                         OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI}) begin
      fmt_o     = FMT_I;
      illegal_o = 1'b0;
      imm_o     = {{(DATA_W-12){IMM12_SIGNED & instr_i[I_IMM_MSB]}},
                   instr_i[I_IMM_MSB:I_IMM_LSB]};
    end else if (instr_i[31:21] inside {OP_LDUR, OP_STUR, OP_LDURSW, OP_STURW,
                                         OP_LDURB, OP_STURB, OP_LDURH, OP_STURH}) begin
      fmt_o     = FMT_D;
      illegal_o = 1'b0;
      imm_o     = {{(DATA_W-9){instr_i[D_IMM_MSB]}}, instr_i[D_IMM_MSB:D_IMM_LSB]};
    end else if (instr_i[31:23] inside {OP_MOVZ, OP_MOVK}) begin
      fmt_o = FMT_IW;
      // A 32-bit datapath cannot hold half-words 2 and 3
      if (DATA_W == 32 && hw[1]) begin
        imm_o     = '0;
        illegal_o = 1'b1;
      end else begin
        imm_o     = iw_wide[DATA_W-1:0];
        illegal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generator pipeline stage: decode, then output register plus one skid entry.
module imm_gen_stage
  import legv8_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter bit          IMM12_SIGNED = 1'b1,
  parameter bit          BR_SHIFT2    = 1'b0
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  imm_gen_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    fmt_e              fmt;
    logic              illegal;
    logic [DATA_W-1:0] pc;
  } entry_t;

  logic [DATA_W-1:0] dec_imm;
  fmt_e              dec_fmt;
  logic              dec_illegal;
  entry_t            new_entry;
  entry_t            out_d, out_q, skid_d, skid_q;
  logic              out_valid_d, out_valid_q;
  logic              skid_valid_d, skid_valid_q;
  logic              in_ready_d, in_ready_q;
  logic              accept_in, out_free;

  imm_decode #(
    .DATA_W      (DATA_W),
    .IMM12_SIGNED(IMM12_SIGNED),
    .BR_SHIFT2   (BR_SHIFT2)
  ) u_imm_decode (
    .instr_i  (bus.in_instr),
    .imm_o    (dec_imm),
    .fmt_o    (dec_fmt),
    .illegal_o(dec_illegal)
  );

  assign new_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, pc: bus.in_pc};
  assign accept_in = bus.in_valid && in_ready_q;
  assign out_free  = !out_valid_q || bus.out_ready;

  // Next state: the skid entry drains to the output before new input, keeping order
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // in_ready_q is low whenever skid is valid, so no input arrives in that case
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_in) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_in) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_pc      = out_q.pc;

endmodule
